// File: rtl/stream_mux_n_pkg.sv
// rtl/stream_mux_n_pkg.sv - shared helpers for the N-channel stream multiplexer
package stream_mux_n_pkg;

    // Channel index reached by stepping off positions past base, modulo n.
    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// rtl/stream_mux_n_rr_arbiter.sv - combinational rotate-and-priority-encode round-robin arbiter
module rr_arbiter
    import stream_mux_n_pkg::*;
#(
    parameter int NCH = 4,
    localparam int CH_W = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [CH_W-1:0] last,
    output logic            gnt_vld,
    output logic [CH_W-1:0] gnt_idx
);

    // Scan last+1, last+2, ... so the previous winner gets lowest priority.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 1; i <= NCH; i++) begin
            if (!gnt_vld && req[wrap_idx(int'(last), i, NCH)]) begin
                gnt_vld = 1'b1;
                gnt_idx = CH_W'(wrap_idx(int'(last), i, NCH));
            end
        end
    end

endmodule

// File: rtl/stream_mux_n.sv
// rtl/stream_mux_n.sv - N-channel registered stream mux with fixed-select or round-robin arbitration
module stream_mux_n
    import stream_mux_n_pkg::*;
#(
    parameter int WIDTH = 7,
    parameter int NCH   = 4,
    localparam int CH_W = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rr_en,
    input  logic [CH_W-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [CH_W-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [CH_W-1:0]  last;
    logic             rr_vld;
    logic [CH_W-1:0]  rr_idx;
    logic             fix_vld;
    logic             grant_vld;
    logic [CH_W-1:0]  grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             slot_free;
    logic             accept;

    rr_arbiter #(.NCH(NCH)) u_rr_arbiter (
        .req     (in_valid),
        .last    (last),
        .gnt_vld (rr_vld),
        .gnt_idx (rr_idx)
    );

    // Compare against each legal index so an out-of-range sel simply never matches.
    always_comb begin
        fix_vld = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (sel == CH_W'(k) && in_valid[k]) begin
                fix_vld = 1'b1;
            end
        end
    end

    assign grant_vld = rr_en ? rr_vld : fix_vld;
    assign grant_idx = rr_en ? rr_idx : sel;
    assign slot_free = !out_valid || out_ready;
    assign accept    = rst_n && slot_free && grant_vld;

    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int k = 0; k < NCH; k++) begin
            if (grant_idx == CH_W'(k)) begin
                grant_data  = in_data[k*WIDTH +: WIDTH];
                in_ready[k] = accept;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            last      <= CH_W'(NCH - 1);
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_ch    <= grant_idx;
                if (rr_en) begin
                    last <= grant_idx;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_n.sv
// tb/tb_stream_mux_n.sv - directed self-checking bench for stream_mux_n
module tb_stream_mux_n;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        rr_en = 1'b0;
    logic [1:0]  sel = '0;
    logic [27:0] in_data = '0;
    logic [3:0]  in_valid = '0;
    logic [3:0]  in_ready;
    logic [6:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_valid;
    logic        out_ready = 1'b1;

    logic        rr_en3 = 1'b0;
    logic [1:0]  sel3 = '0;
    logic [20:0] in_data3 = '0;
    logic [2:0]  in_valid3 = '0;
    logic [2:0]  in_ready3;
    logic [6:0]  out_data3;
    logic [1:0]  out_ch3;
    logic        out_valid3;
    logic        out_ready3 = 1'b1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stream_mux_n #(.WIDTH(7), .NCH(4)) dut (
        .clk(clk), .rst_n(rst_n), .rr_en(rr_en), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    stream_mux_n #(.WIDTH(7), .NCH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .rr_en(rr_en3), .sel(sel3),
        .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out_data(out_data3), .out_ch(out_ch3), .out_valid(out_valid3), .out_ready(out_ready3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rr_en = 1'b1;
        in_valid = 4'b1111;
        #1;
        checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_data !== 7'h00) begin failures++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
        checks++; if (out_ch !== 2'd0) begin failures++; $display("FAIL reset_out_ch got=%0d exp=0", out_ch); end
        in_valid = 4'b0000;
        rr_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fixed_select();
        rr_en = 1'b0;
        out_ready = 1'b1;
        in_data = {7'h00, 7'h55, 7'h00, 7'h00};
        sel = 2'd1;
        in_valid = 4'b0100;
        #1;
        checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL fix_sel_not_valid got=%b exp=0000", in_ready); end
        sel = 2'd2;
        #1;
        checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL fix_in_ready got=%b exp=0100", in_ready); end
        tick();
        in_valid = 4'b0000;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fix_out_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 7'h55) begin failures++; $display("FAIL fix_out_data got=%h exp=55", out_data); end
        checks++; if (out_ch !== 2'd2) begin failures++; $display("FAIL fix_out_ch got=%0d exp=2", out_ch); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL fix_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ch;
        in_data = {7'h13, 7'h12, 7'h11, 7'h10};
        rr_en = 1'b1;
        in_valid = 4'b1111;
        #1;
        checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL rr_first_ready got=%b exp=0001", in_ready); end
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_ch = 2'(i % 4);
            checks++; if (out_valid !== 1'b1 || out_ch !== exp_ch || out_data !== 7'h10 + 7'(exp_ch)) begin
                failures++;
                $display("FAIL rr_beat%0d got v=%b ch=%0d d=%h exp v=1 ch=%0d d=%h", i, out_valid, out_ch, out_data, exp_ch, 7'h10 + 7'(exp_ch));
            end
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        #1;
        checks++; if (in_ready !== 4'b0000) begin failures++; $display("FAIL bp_in_ready got=%b exp=0000", in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 7'h11 || in_ready !== 4'b0000) begin
                failures++;
                $display("FAIL bp_hold%0d got v=%b ch=%0d d=%h rdy=%b exp v=1 ch=1 d=11 rdy=0000", i, out_valid, out_ch, out_data, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0100) begin failures++; $display("FAIL bp_release_ready got=%b exp=0100", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 7'h12) begin
            failures++;
            $display("FAIL bp_drain_accept got v=%b ch=%0d d=%h exp v=1 ch=2 d=12", out_valid, out_ch, out_data);
        end
        in_valid = 4'b0000;
        tick();
        checks++; if (out_valid !== 1'b0 || out_ch !== 2'd2 || out_data !== 7'h12) begin
            failures++;
            $display("FAIL bp_drain_hold got v=%b ch=%0d d=%h exp v=0 ch=2 d=12", out_valid, out_ch, out_data);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_seq [0:2];
        exp_seq[0] = 2'd3;
        exp_seq[1] = 2'd1;
        exp_seq[2] = 2'd3;
        in_valid = 4'b0010;
        #1;
        checks++; if (in_ready !== 4'b0010) begin failures++; $display("FAIL wrap_setup got=%b exp=0010", in_ready); end
        tick();
        in_valid = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== (4'b0001 << exp_seq[i])) begin
                failures++;
                $display("FAIL wrap_ready%0d got=%b exp=%b", i, in_ready, 4'b0001 << exp_seq[i]);
            end
            tick();
            checks++; if (out_valid !== 1'b1 || out_ch !== exp_seq[i]) begin
                failures++;
                $display("FAIL wrap_beat%0d got v=%b ch=%0d exp v=1 ch=%0d", i, out_valid, out_ch, exp_seq[i]);
            end
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_nch3();
        in_data3 = {7'h22, 7'h21, 7'h20};
        rr_en3 = 1'b0;
        sel3 = 2'd3;
        in_valid3 = 3'b111;
        #1;
        checks++; if (in_ready3 !== 3'b000) begin failures++; $display("FAIL nch3_sel3_ready got=%b exp=000", in_ready3); end
        tick();
        checks++; if (out_valid3 !== 1'b0) begin failures++; $display("FAIL nch3_sel3_valid got=%b exp=0", out_valid3); end
        sel3 = 2'd2;
        #1;
        checks++; if (in_ready3 !== 3'b100) begin failures++; $display("FAIL nch3_sel2_ready got=%b exp=100", in_ready3); end
        tick();
        in_valid3 = 3'b000;
        checks++; if (out_valid3 !== 1'b1 || out_ch3 !== 2'd2 || out_data3 !== 7'h22) begin
            failures++;
            $display("FAIL nch3_sel2_beat got v=%b ch=%0d d=%h exp v=1 ch=2 d=22", out_valid3, out_ch3, out_data3);
        end
    endtask

    task automatic test_async_reset();
        rr_en = 1'b1;
        out_ready = 1'b0;
        in_valid = 4'b0100;
        tick();
        in_valid = 4'b1111;
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'd2) begin
            failures++;
            $display("FAIL areset_pre got v=%b ch=%0d exp v=1 ch=2", out_valid, out_ch);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 7'h00 || out_ch !== 2'd0 || in_ready !== 4'b0000) begin
            failures++;
            $display("FAIL areset_now got v=%b d=%h ch=%0d rdy=%b exp v=0 d=00 ch=0 rdy=0000", out_valid, out_data, out_ch, in_ready);
        end
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 4'b0001) begin failures++; $display("FAIL areset_first_ready got=%b exp=0001", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 7'h10) begin
            failures++;
            $display("FAIL areset_first_beat got v=%b ch=%0d d=%h exp v=1 ch=0 d=10", out_valid, out_ch, out_data);
        end
        in_valid = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_fixed_select();
        test_round_robin();
        test_backpressure();
        test_wrap();
        test_nch3();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
